// File: rtl/simon_iter_core.sv
// rtl/simon_iter_core.sv - iterative SIMON encrypt/decrypt engine with on-chip key expansion
module simon_iter_core #(
    parameter int          N = 16,
    parameter int          M = 4,
    parameter int          T = 32,
    // Element i of the z sequence lives in bit i (default z0).
    parameter logic [61:0] Z = 62'b01_1001110000_1101010010_0010111110_1100111000_0110101001_0001011111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_load,
    input  logic [M*N-1:0]   key,
    output logic             key_rdy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [2*N-1:0]   din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   dout
);

    localparam int IW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPAND,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [N-1:0]    rk [T];
    logic [IW-1:0]   idx;
    logic [5:0]      zidx;
    logic [IW-1:0]   rnd;
    logic            mode_q;
    logic [2*N-1:0]  blk;

    logic            load;
    logic            accept;
    logic            round_last;
    logic [N-1:0]    rk_new;
    logic [N-1:0]    rk_cur;
    logic [2*N-1:0]  blk_next;

    function automatic logic [N-1:0] rol(input logic [N-1:0] x, input int k);
        return (x << k) | (x >> (N - k));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int k);
        return (x >> k) | (x << (N - k));
    endfunction

    function automatic logic [N-1:0] f(input logic [N-1:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    // A new key is only taken when no block is in flight; key_load beats a same-cycle in_valid.
    assign load   = key_load && (state == S_IDLE || state == S_READY);
    assign accept = (state == S_READY) && in_valid && !key_load;

    // Terminal count of the round counter: top for encrypt, zero for decrypt.
    assign round_last = mode_q ? (rnd == '0) : (rnd == IW'(T - 1));

    // Next round key from the words already in the bank.
    always_comb begin
        logic [N-1:0] t;
        t = ror(rk[idx - IW'(1)], 3);
        if (M == 4) begin
            t = t ^ rk[idx - IW'(3)];
        end
        t      = t ^ ror(t, 1);
        rk_new = ~rk[idx - IW'(M)] ^ t ^ N'(Z[zidx]) ^ N'(3);
    end

    // One encrypt or inverse round on the working block.
    always_comb begin
        logic [N-1:0] x1;
        logic [N-1:0] x0;
        x1     = blk[2*N-1:N];
        x0     = blk[N-1:0];
        rk_cur = rk[rnd];
        if (!mode_q) begin
            blk_next = {x0 ^ f(x1) ^ rk_cur, x1};
        end else begin
            blk_next = {x0, x1 ^ f(x0) ^ rk_cur};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        key_rdy    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_load) state_next = S_EXPAND;
            end
            S_EXPAND: begin
                if (idx == IW'(T - 1)) state_next = S_READY;
            end
            S_READY: begin
                key_rdy  = 1'b1;
                in_ready = 1'b1;
                if (key_load)      state_next = S_EXPAND;
                else if (in_valid) state_next = S_RUN;
            end
            S_RUN: begin
                key_rdy = 1'b1;
                if (round_last) state_next = S_DONE;
            end
            S_DONE: begin
                key_rdy   = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = S_READY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Round-key bank: master words on load, one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < M; j++) begin
                rk[j] <= key[j*N +: N];
            end
        end else if (state == S_EXPAND) begin
            rk[idx] <= rk_new;
        end
    end

    // Expansion index, z-sequence pointer, round counter and block datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            zidx   <= '0;
            rnd    <= '0;
            mode_q <= 1'b0;
            blk    <= '0;
            dout   <= '0;
        end else begin
            if (load) begin
                idx  <= IW'(M);
                zidx <= '0;
            end else if (state == S_EXPAND) begin
                if (idx != IW'(T - 1)) idx <= idx + IW'(1);
                zidx <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
            end

            if (accept) begin
                blk    <= din;
                mode_q <= mode;
                rnd    <= mode ? IW'(T - 1) : '0;
            end else if (state == S_RUN) begin
                blk <= blk_next;
                if (round_last) begin
                    dout <= blk_next;
                end else if (mode_q) begin
                    rnd <= rnd - IW'(1);
                end else begin
                    rnd <= rnd + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_simon_iter_core.sv
// tb/tb_simon_iter_core.sv - directed and random scoreboard bench for simon_iter_core
module tb_simon_iter_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_load;
    logic [63:0] key;
    logic        key_rdy;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q [$];
    logic [15:0] mrk [32];
    string       zs = "11111010001001010110000111001101111101000100101011000011100110";

    simon_iter_core dut (
        .clk       (clk),
        .reset     (reset),
        .key_load  (key_load),
        .key       (key),
        .key_rdy   (key_rdy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rl(input logic [15:0] x, input int k);
        return (x << k) | (x >> (16 - k));
    endfunction

    function automatic logic [15:0] fm(input logic [15:0] x);
        return (rl(x, 1) & rl(x, 8)) ^ rl(x, 2);
    endfunction

    task automatic model_keys(input logic [63:0] k);
        logic [15:0] t;
        logic [15:0] c;
        for (int i = 0; i < 4; i++) mrk[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rl(mrk[i-1], 13) ^ mrk[i-3];
            t = t ^ rl(t, 15);
            c = 16'hfffc ^ ((zs[(i-4) % 62] == "1") ? 16'h0001 : 16'h0000);
            mrk[i] = c ^ mrk[i-4] ^ t;
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic m);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] tmp;
        a = d[31:16];
        b = d[15:0];
        if (!m) begin
            for (int i = 0; i < 32; i++) begin
                tmp = a;
                a   = b ^ fm(a) ^ mrk[i];
                b   = tmp;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                tmp = b;
                b   = a ^ fm(b) ^ mrk[i];
                a   = tmp;
            end
        end
        return {a, b};
    endfunction

    task automatic load_key(input logic [63:0] k);
        int cnt;
        key      = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key      = $urandom;
        cnt      = 1;
        while (!key_rdy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("key_rdy_latency", cnt, 29);
        model_keys(k);
    endtask

    task automatic send(input logic [31:0] d, input logic m, input logic [31:0] exp);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        din      = d;
        mode     = m;
        tick();
        in_valid = 1'b0;
        din      = $urandom;
        mode     = $urandom_range(0, 1);
        sb_q.push_back(exp);
    endtask

    task automatic recv(input int stall);
        int cnt;
        logic [31:0] exp;
        out_ready = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("out_valid_wait", out_valid, 1'b1);
        repeat (stall) tick();
        out_ready = 1'b1;
        chk("sb_nonempty", sb_q.size() > 0, 1'b1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'h0;
        chk("dout", dout, exp);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int received;
        logic [31:0] held;
        logic [31:0] d;
        logic        m;

        reset     = 1'b1;
        key_load  = 1'b0;
        key       = '0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_key_rdy", key_rdy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dout", dout, 32'h0);
        reset = 1'b0;
        tick();

        load_key(64'h1918_1110_0908_0100);

        // Known-answer encrypt with latency measurement.
        send(32'h65656877, 1'b0, 32'hc69be9bb);
        cnt = 1;
        while (!out_valid && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("enc_latency", cnt, 33);
        recv(0);

        // Known-answer decrypt, held in DONE with out_ready low for 10 cycles.
        send(32'hc69be9bb, 1'b1, 32'h65656877);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            tick();
            cnt++;
        end
        held = dout;
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_dout", dout, held);
            chk("stall_in_ready", in_ready, 1'b0);
            tick();
        end
        recv(0);
        chk("ready_after_release", in_ready, 1'b1);

        // key_load wins over a same-cycle in_valid in READY.
        key      = 64'h1918_1110_0908_0100;
        key_load = 1'b1;
        in_valid = 1'b1;
        din      = 32'h12345678;
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        chk("collide_in_ready", in_ready, 1'b0);
        chk("collide_key_rdy", key_rdy, 1'b0);
        cnt = 0;
        while (!key_rdy && cnt < 100) begin
            chk("collide_no_output", out_valid, 1'b0);
            tick();
            cnt++;
        end
        chk("collide_reexpand", key_rdy, 1'b1);
        repeat (3) begin
            chk("collide_still_idle", out_valid, 1'b0);
            tick();
        end
        send(32'h65656877, 1'b0, 32'hc69be9bb);
        recv(2);

        // Reset in the middle of RUN.
        in_valid = 1'b1;
        din      = 32'h0badf00d;
        mode     = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("midrun_key_rdy", key_rdy, 1'b0);
        chk("midrun_out_valid", out_valid, 1'b0);
        chk("midrun_in_ready", in_ready, 1'b0);
        chk("midrun_dout", dout, 32'h0);
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("postrst_in_ready", in_ready, 1'b0);
            chk("postrst_out_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;

        // Reload a different key and stream random blocks with random stalls.
        load_key({$urandom, $urandom});
        received = 0;
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            m = $urandom_range(0, 1);
            send(d, m, model(d, m));
            recv($urandom_range(0, 3));
            received++;
        end
        chk("stream_count", received, 100);
        chk("stream_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
